// File: rtl/player_input_pkg.sv
// Shared register map, bit positions and decode types for the player input bank.
package player_input_pkg;

  localparam logic [11:0] ADDR_CTRL   = 12'd0;
  localparam logic [11:0] ADDR_STATUS = 12'd1;
  localparam logic [11:0] ADDR_KEY0   = 12'd2;

  localparam int FLUSH_BIT = 8;
  localparam int EMPTY_LSB = 8;
  localparam int EMPTY_BIT = 16;
  localparam int FULL_BIT  = 17;
  localparam int LEVEL_LSB = 24;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_CTRL,
    SEL_STATUS,
    SEL_KEY
  } reg_sel_t;

  function automatic logic [11:0] key_addr(input int ch);
    return ADDR_KEY0 + 12'(ch);
  endfunction

endpackage

// File: rtl/player_input_bank_key_fifo.sv
// One player's keycode queue plus the held key it presents after each pop.
module key_fifo #(
  parameter  int DEPTH = 8,
  parameter  int W     = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic          ovf_clr,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          fresh,
  output logic          empty,
  output logic          full,
  output logic [LW-1:0] level,
  output logic          overflow
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push_ok, pop_ok, ovf_set;

  assign empty = (level == '0);
  assign full  = (level == LW'(DEPTH));

  // A pop on an empty queue is ignored, so a same-cycle push never bypasses to dout.
  assign pop_ok  = pop & ~empty & ~flush;
  assign push_ok = push & (~full | pop) & ~flush;
  assign ovf_set = push & full & ~pop & ~flush;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      dout     <= '0;
      fresh    <= 1'b0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      fresh    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      fresh <= pop_ok;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
        dout   <= mem[rd_ptr];
      end
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/player_input_bank.sv
// Avalon-MM slave feeding per-player keycode queues; also holds the global game mode.
module player_input_bank
  import player_input_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int KEY_W      = 8,
  parameter int MODE_W     = 3
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    AVL_READ,
  input  logic                    AVL_WRITE,
  input  logic                    AVL_CS,
  input  logic [3:0]              AVL_BYTE_EN,
  input  logic [11:0]             AVL_ADDR,
  input  logic [31:0]             AVL_WRITEDATA,
  output logic [31:0]             AVL_READDATA,
  input  logic [NUM_CH-1:0]       key_pop,
  output logic [NUM_CH*KEY_W-1:0] key_out,
  output logic [NUM_CH-1:0]       key_fresh,
  output logic [MODE_W-1:0]       game_mode
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic              wr, rd, flush, mode_we;
  logic [NUM_CH-1:0] push, ovf_clr, empty, full, overflow;
  logic [KEY_W-1:0]  key_arr   [NUM_CH];
  logic [LW-1:0]     level_arr [NUM_CH];
  reg_sel_t          sel;
  logic [31:0]       rd_mux;

  // Write wins when both strobes are up, so such a cycle is not a read.
  assign wr = AVL_WRITE & AVL_CS;
  assign rd = AVL_READ & AVL_CS & ~AVL_WRITE;

  always_comb begin
    if (AVL_ADDR == ADDR_CTRL)
      sel = SEL_CTRL;
    else if (AVL_ADDR == ADDR_STATUS)
      sel = SEL_STATUS;
    else if (AVL_ADDR >= ADDR_KEY0 && AVL_ADDR < ADDR_KEY0 + 12'(NUM_CH))
      sel = SEL_KEY;
    else
      sel = SEL_NONE;
  end

  assign mode_we = wr && (sel == SEL_CTRL) && AVL_BYTE_EN[0];
  assign flush   = wr && (sel == SEL_CTRL) && AVL_BYTE_EN[1] && AVL_WRITEDATA[FLUSH_BIT];

  always_comb begin
    push    = '0;
    ovf_clr = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      push[c]    = wr && !flush && AVL_BYTE_EN[0] && (AVL_ADDR == key_addr(c));
      ovf_clr[c] = wr && (sel == SEL_STATUS) && AVL_BYTE_EN[0] && AVL_WRITEDATA[c];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    key_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (KEY_W)
    ) u_fifo (
      .clk      (CLK),
      .rst_n    (RESET_N),
      .push     (push[g]),
      .pop      (key_pop[g]),
      .flush    (flush),
      .ovf_clr  (ovf_clr[g]),
      .din      (AVL_WRITEDATA[KEY_W-1:0]),
      .dout     (key_arr[g]),
      .fresh    (key_fresh[g]),
      .empty    (empty[g]),
      .full     (full[g]),
      .level    (level_arr[g]),
      .overflow (overflow[g])
    );
    assign key_out[g*KEY_W +: KEY_W] = key_arr[g];
  end

  always_comb begin
    rd_mux = '0;
    case (sel)
      SEL_CTRL: rd_mux[MODE_W-1:0] = game_mode;
      SEL_STATUS: begin
        rd_mux[NUM_CH-1:0]          = overflow;
        rd_mux[EMPTY_LSB +: NUM_CH] = empty;
      end
      SEL_KEY: begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (AVL_ADDR == key_addr(c)) begin
            rd_mux[KEY_W-1:0]       = key_arr[c];
            rd_mux[EMPTY_BIT]       = empty[c];
            rd_mux[FULL_BIT]        = full[c];
            rd_mux[LEVEL_LSB +: LW] = level_arr[c];
          end
        end
      end
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      AVL_READDATA <= '0;
      game_mode    <= '0;
    end else begin
      if (rd)      AVL_READDATA <= rd_mux;
      if (mode_we) game_mode    <= AVL_WRITEDATA[MODE_W-1:0];
    end
  end

endmodule

// File: tb/tb_player_input_bank.sv
// Randomized scoreboard bench for player_input_bank against a queue-based reference model.
module tb_player_input_bank;

  localparam int NUM_CH = 2;
  localparam int DEPTH  = 8;
  localparam int KEY_W  = 8;
  localparam int MODE_W = 3;

  logic                    CLK = 1'b0;
  logic                    RESET_N;
  logic                    AVL_READ, AVL_WRITE, AVL_CS;
  logic [3:0]              AVL_BYTE_EN;
  logic [11:0]             AVL_ADDR;
  logic [31:0]             AVL_WRITEDATA;
  logic [31:0]             AVL_READDATA;
  logic [NUM_CH-1:0]       key_pop;
  logic [NUM_CH*KEY_W-1:0] key_out;
  logic [NUM_CH-1:0]       key_fresh;
  logic [MODE_W-1:0]       game_mode;

  player_input_bank #(
    .NUM_CH(NUM_CH), .FIFO_DEPTH(DEPTH), .KEY_W(KEY_W), .MODE_W(MODE_W)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
    .AVL_CS(AVL_CS), .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_ADDR(AVL_ADDR),
    .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(AVL_READDATA), .key_pop(key_pop),
    .key_out(key_out), .key_fresh(key_fresh), .game_mode(game_mode)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [NUM_CH-1:0]       fresh;
    logic [NUM_CH*KEY_W-1:0] keys;
    logic [MODE_W-1:0]       mode;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] rd_q [$];
  exp_t        out_q [$];
  logic        issued = 1'b0;
  logic        rd_issued = 1'b0;

  // reference model: one queue per player, plus held key, sticky bits and mode
  logic [KEY_W-1:0]  mq [NUM_CH][$];
  logic [KEY_W-1:0]  m_key [NUM_CH];
  logic [NUM_CH-1:0] m_ovf;
  logic [NUM_CH-1:0] m_fresh;
  logic [MODE_W-1:0] m_mode;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      mq[c].delete();
      m_key[c] = '0;
    end
    m_ovf   = '0;
    m_fresh = '0;
    m_mode  = '0;
  endfunction

  function automatic logic [31:0] read_exp(input logic [11:0] a);
    logic [31:0] r;
    int          c;
    r = '0;
    if (a == 12'd0) begin
      r[MODE_W-1:0] = m_mode;
    end else if (a == 12'd1) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r[i]     = m_ovf[i];
        r[8 + i] = (mq[i].size() == 0);
      end
    end else if (int'(a) >= 2 && int'(a) < 2 + NUM_CH) begin
      c = int'(a) - 2;
      r[KEY_W-1:0] = m_key[c];
      r[16]        = (mq[c].size() == 0);
      r[17]        = (mq[c].size() == DEPTH);
      r[31:24]     = 8'(mq[c].size());
    end
    return r;
  endfunction

  function automatic void model_step(input logic wr, input logic [11:0] a, input logic [3:0] be,
                                     input logic [31:0] wd, input logic [NUM_CH-1:0] pop);
    int pre;
    m_fresh = '0;
    if (wr && a == 12'd0 && be[0]) m_mode = wd[MODE_W-1:0];
    if (wr && a == 12'd0 && be[1] && wd[8]) begin
      for (int c = 0; c < NUM_CH; c++) mq[c].delete();
      m_ovf = '0;
      return;
    end
    if (wr && a == 12'd1 && be[0]) m_ovf = m_ovf & ~wd[NUM_CH-1:0];
    for (int c = 0; c < NUM_CH; c++) begin
      pre = mq[c].size();
      if (pop[c] && pre > 0) begin
        m_key[c]   = mq[c].pop_front();
        m_fresh[c] = 1'b1;
      end
      if (wr && int'(a) == 2 + c && be[0]) begin
        if (pre == DEPTH && !pop[c]) m_ovf[c] = 1'b1;
        else mq[c].push_back(wd[KEY_W-1:0]);
      end
    end
  endfunction

  task automatic drive(input logic rd, input logic wr, input logic [11:0] a, input logic [3:0] be,
                       input logic [31:0] wd, input logic [NUM_CH-1:0] pop, input logic cs = 1'b1);
    exp_t e;
    @(negedge CLK);
    AVL_READ = rd; AVL_WRITE = wr; AVL_CS = cs; AVL_ADDR = a;
    AVL_BYTE_EN = be; AVL_WRITEDATA = wd; key_pop = pop;
    issued    = 1'b1;
    rd_issued = cs & rd & ~wr;
    if (rd_issued) rd_q.push_back(read_exp(a));
    model_step(cs & wr, a, be, wd, pop);
    e.fresh = m_fresh;
    for (int c = 0; c < NUM_CH; c++) e.keys[c*KEY_W +: KEY_W] = m_key[c];
    e.mode = m_mode;
    out_q.push_back(e);
  endtask

  task automatic rd_reg(input logic [11:0] a);
    drive(1'b1, 1'b0, a, 4'h0, 32'h0, '0);
  endtask

  task automatic wr_reg(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be = 4'hF,
                        input logic [NUM_CH-1:0] pop = '0);
    drive(1'b0, 1'b1, a, be, d, pop);
  endtask

  task automatic pop_ch(input logic [NUM_CH-1:0] p);
    drive(1'b0, 1'b0, 12'd0, 4'h0, 32'h0, p);
  endtask

  // monitor: compares whatever the DUT presents one edge after each issued cycle
  initial begin
    logic b_rd;
    exp_t e;
    forever begin
      @(posedge CLK);
      if (issued) begin
        b_rd = rd_issued;
        #1;
        if (b_rd) begin
          if (rd_q.size() == 0) check("rd_queue_underflow", 64'd1, 64'd0);
          else check("readdata", 64'(AVL_READDATA), 64'(rd_q.pop_front()));
        end
        if (out_q.size() == 0) begin
          check("out_queue_underflow", 64'd1, 64'd0);
        end else begin
          e = out_q.pop_front();
          check("key_fresh", 64'(key_fresh), 64'(e.fresh));
          check("key_out", 64'(key_out), 64'(e.keys));
          check("game_mode", 64'(game_mode), 64'(e.mode));
        end
      end
    end
  end

  initial begin
    logic [11:0]       a;
    logic [31:0]       d;
    logic [NUM_CH-1:0] p;
    RESET_N = 1'b0;
    AVL_READ = 1'b0; AVL_WRITE = 1'b0; AVL_CS = 1'b0;
    AVL_BYTE_EN = '0; AVL_ADDR = '0; AVL_WRITEDATA = '0; key_pop = '0;
    model_reset();
    repeat (3) @(posedge CLK);
    #2;
    check("rst_readdata", 64'(AVL_READDATA), 64'd0);
    check("rst_key_out", 64'(key_out), 64'd0);
    check("rst_key_fresh", 64'(key_fresh), 64'd0);
    check("rst_game_mode", 64'(game_mode), 64'd0);
    @(negedge CLK);
    RESET_N = 1'b1;

    rd_reg(12'd0); rd_reg(12'd1); rd_reg(12'd2);

    wr_reg(12'd2, 32'h1A); wr_reg(12'd2, 32'h07);
    repeat (3) pop_ch(2'b01);
    rd_reg(12'd2);

    for (int i = 0; i < 9; i++) wr_reg(12'd3, 32'h40 + 32'(i));
    rd_reg(12'd3); rd_reg(12'd1);
    wr_reg(12'd1, 32'h2, 4'h1);
    rd_reg(12'd1);
    repeat (9) pop_ch(2'b10);
    rd_reg(12'd3);

    for (int i = 0; i < 8; i++) wr_reg(12'd2, 32'h60 + 32'(i));
    wr_reg(12'd2, 32'h55, 4'h1, 2'b01);
    rd_reg(12'd2); rd_reg(12'd1);
    repeat (8) pop_ch(2'b01);
    rd_reg(12'd2);

    wr_reg(12'd2, 32'h16, 4'h1, 2'b01);
    rd_reg(12'd2);
    pop_ch(2'b01);
    rd_reg(12'd2);

    wr_reg(12'd2, 32'h21); wr_reg(12'd2, 32'h22); wr_reg(12'd3, 32'h31);
    wr_reg(12'd0, 32'h105, 4'h3);
    rd_reg(12'd0); rd_reg(12'd2); rd_reg(12'd3); rd_reg(12'd1);
    pop_ch(2'b11);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    a = 12'($urandom_range(0, 1));
        2:       a = 12'($urandom_range(4, 4095));
        default: a = 12'($urandom_range(2, 1 + NUM_CH));
      endcase
      d = $urandom;
      if (a == 12'd0 && $urandom_range(0, 7) != 0) d[8] = 1'b0;
      p = '0;
      for (int c = 0; c < NUM_CH; c++) p[c] = ($urandom_range(0, 9) < 3);
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0), a,
            ($urandom_range(0, 4) != 0) ? 4'hF : 4'($urandom_range(0, 15)), d, p,
            ($urandom_range(0, 9) != 0));
    end

    for (int i = 0; i < 4; i++) wr_reg(12'd2, 32'h70 + 32'(i));
    wr_reg(12'd0, 32'h6, 4'h1);
    pop_ch(2'b01);
    @(posedge CLK);
    #3;
    issued = 1'b0;
    RESET_N = 1'b0;
    #1;
    check("async_rst_key_out", 64'(key_out), 64'd0);
    check("async_rst_key_fresh", 64'(key_fresh), 64'd0);
    check("async_rst_game_mode", 64'(game_mode), 64'd0);
    check("async_rst_readdata", 64'(AVL_READDATA), 64'd0);
    check("scoreboard_drained", 64'(rd_q.size() + out_q.size()), 64'd0);
    rd_q.delete();
    out_q.delete();
    model_reset();
    @(negedge CLK);
    RESET_N = 1'b1;
    rd_reg(12'd1); rd_reg(12'd2);
    pop_ch(2'b01);
    @(posedge CLK);
    #3;
    issued = 1'b0;
    check("final_drained", 64'(rd_q.size() + out_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
